fir_lpf_ctrl: RTL

- Time-multiplexed sequencer for the FIR low-pass datapath: one MAC unit, one sample RAM (circular delay line), one coefficient ROM.
- On each rising edge of the sample-rate strobe f_s, it:
  - writes the new input sample into the delay line;
  - steps TAPS read addresses through RAM/ROM while driving MAC clear/enable;
  - pulses dout_vld when the accumulated result is ready.
- Sits between the input mux and the MAC/rounding stage; runs entirely in the clk domain.

---
 rtl/fir_lpf_ctrl_pkg.sv | 24 ++
 rtl/fs_edge_sync.sv | 28 ++
 rtl/fir_lpf_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fir_lpf_ctrl_pkg.sv
// Shared types and default constants for the FIR low-pass sequencer.
package fir_lpf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_MAC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fir_state_e;

  localparam int TAPS_DEF   = 32;
  localparam int DW_DEF     = 12;
  localparam int RD_LAT_DEF = 1;

  // Address width for a power-of-two tap count.
  function automatic int fir_aw(input int taps);
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) >= taps) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/fs_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector; rise_o pulses
// for one clk cycle, three cycles after the asynchronous input rises.
module fs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/fir_lpf_ctrl.sv
// Time-multiplexed FIR sequencer: delay-line write, tap address stepping, MAC
// control and result strobe. FIR_LPF_CTRL_SYM_EN enables symmetric folding.
module fir_lpf_ctrl
  import fir_lpf_ctrl_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int AW     = fir_aw(TAPS),
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_s,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          ovr_clr,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [DW-1:0] smp_wdata,
  output logic [AW-1:0] smp_raddr,
`ifdef FIR_LPF_CTRL_SYM_EN
  output logic [AW-1:0] smp_raddr2,
`endif
  output logic [AW-1:0] coef_raddr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  output logic          dout_vld,
  output logic          busy,
  output logic          overrun,
  output logic [2:0]    dbg_state
);

`ifdef FIR_LPF_CTRL_SYM_EN
  localparam int MAC_N = TAPS / 2;
  localparam logic [AW-1:0] TAP_TOP = AW'(TAPS - 1);
`else
  localparam int MAC_N = TAPS;
`endif
  localparam logic [AW-1:0] LAST_I = AW'(MAC_N - 1);
  localparam logic [1:0]    FL_END = 2'(RD_LAT - 1);

  fir_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     tap_q, tap_d;
  logic [1:0]        fl_q, fl_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic [RD_LAT-1:0] iss_q, first_q, last_q;
  logic              overrun_q;
  logic              fs_rise, issue;

  fs_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst),
    .async_i(f_s),
    .rise_o (fs_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      tap_q    <= '0;
      fl_q     <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      tap_q    <= tap_d;
      fl_q     <= fl_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    tap_d    = tap_q;
    fl_d     = fl_q;
    hold_d   = hold_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fs_rise && en) begin
          hold_d  = din;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        tap_d   = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        issue = 1'b1;
        if (tap_q == LAST_I) begin
          tap_d   = '0;
          fl_d    = '0;
          state_d = ST_FLUSH;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
      ST_FLUSH: begin
        if (fl_q == FL_END) state_d = ST_DONE;
        else                fl_d = fl_q + 2'd1;
      end
      ST_DONE: begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-issue strobe and its first/last markers ride a RD_LAT-deep
  // pipe so the MAC controls line up with the returning RAM/ROM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      iss_q[0]   <= issue;
      first_q[0] <= issue && (tap_q == '0);
      last_q[0]  <= issue && (tap_q == LAST_I);
      for (int j = 1; j < RD_LAT; j++) begin
        iss_q[j]   <= iss_q[j-1];
        first_q[j] <= first_q[j-1];
        last_q[j]  <= last_q[j-1];
      end
    end
  end

  // A new overrun takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           overrun_q <= 1'b0;
    else if (fs_rise && en && busy)     overrun_q <= 1'b1;
    else if (ovr_clr)                   overrun_q <= 1'b0;
  end

  assign smp_we     = (state_q == ST_WRITE);
  assign smp_waddr  = smp_we ? wr_ptr_q : '0;
  assign smp_wdata  = smp_we ? hold_q : '0;
  assign smp_raddr  = issue ? (wr_ptr_q - tap_q) : '0;
`ifdef FIR_LPF_CTRL_SYM_EN
  assign smp_raddr2 = issue ? (wr_ptr_q - TAP_TOP + tap_q) : '0;
`endif
  assign coef_raddr = issue ? tap_q : '0;
  assign mac_en     = iss_q[RD_LAT-1];
  assign mac_clr    = first_q[RD_LAT-1];
  assign mac_last   = last_q[RD_LAT-1];
  assign dout_vld   = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule
